tile_board_mmio: RTL and testbench
==================================

Name: tile_board_mmio

Overview:
- Parametrised, memory-mapped tile-state bank for the rotating memory game. Replaces the fixed 16-tile ON/COLOR/SOLVED register set inside the data RAM.
- Sits on the processor data-memory bus beside the RAM. It drives packed tile vectors to the VGA controller.
- Adds three functions:
  - a button-event FIFO readable by the CPU;
  - a frame-counted auto-hide timer for revealed tiles;
  - an aggregate solved/status register.

Parameters:
- NUM_TILES, 16: number of tiles, 1..64.
- COLOR_W, 12: tile colour width, 1..20.
- ADDR_W, 12: bus address width.
- BASE_ADDR, 12'hF00: word address of tile 0.
- TIMER_W, 16: reveal-timer width.
- FIFO_DEPTH, 4: button event FIFO entries, a power of 2 between 2 and 16.

Ports:
- clock, in, 1: system clock; all logic rises on its posedge.
- reset, in, 1: asynchronous, active-high reset.
- wEn, in, 1: bus write strobe.
- rEn, in, 1: bus read strobe. Only reads that assert rEn have side effects.
- addr, in, ADDR_W: bus word address.
- dataIn, in, 32: write data.
- dataOut, out, 32: registered read data.
- btn, in, 4: synchronised button levels {BTND, BTNU, BTNL, BTNR}.
- frame_tick, in, 1: single-cycle pulse, once per video frame.
- tile_on, out, NUM_TILES: bit i is tile i visible.
- tile_color, out, NUM_TILES*COLOR_W: tile i colour occupies bits [i*COLOR_W +: COLOR_W].
- tile_solved, out, NUM_TILES: bit i is tile i solved.
- all_solved, out, 1: AND of tile_solved.
- irq, out, 1: high while the FIFO is non-empty.

Behaviour:
- Register map, word offset from BASE_ADDR:
  - 0..NUM_TILES-1, TILE[i]: bit0 ON, bit1 SOLVED, bits[8 +: COLOR_W] COLOR.
  - NUM_TILES+0, REVEAL: bits[TIMER_W-1:0] hold the reload value in frames.
  - NUM_TILES+1, EVENT: read-to-pop. Returns {valid in bit31, 27'b0, mask[3:0]}. Writes are ignored.
  - NUM_TILES+2, STATUS:
    - bit0 all_solved.
    - bit1 overflow, sticky; writing bit1=1 clears it.
    - bits[12:8] FIFO count.
    - bits[31:16] current timer value.
  - NUM_TILES+3, CTRL: bit0 autohide_en. All other bits read 0.
- Addresses outside the map: reads return 0, writes are ignored, and no side effects occur.
- Write path:
  - When wEn=1 and addr hits, the register updates at the posedge.
  - Unused bits read back as 0.
  - If wEn and rEn are both 1, the write wins and no pop occurs.
- Read path:
  - When rEn=1, dataOut is loaded at the posedge with the pre-edge contents of addr. Latency is 1 cycle.
  - When rEn=0, dataOut holds its value.
- Button edge detection:
  - The module registers btn. rise = btn & ~btn_q.
  - Any nonzero rise pushes one entry containing the full 4-bit mask. Simultaneous presses therefore produce one entry, not several.
- FIFO behaviour:
  - Push when full: entry dropped, overflow set, count stays FIFO_DEPTH.
  - Pop when empty: returns valid=0 and mask=0; state unchanged.
  - Push and pop in the same cycle when non-empty: both occur, count unchanged, the oldest entry is returned.
  - Push and pop in the same cycle when empty: the pop returns valid=0 and the push is stored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reveal timer, shared by all tiles. States: IDLE and COUNTING.
  - Arm: a TILE[i] write with ON=1 and SOLVED=0 while autohide_en=1 loads timer=REVEAL and enters COUNTING. This also applies while already COUNTING (restart).
  - Count: in COUNTING, each frame_tick decrements the timer.
  - Expiry: when a frame_tick occurs with timer==1, every tile with ON=1 and SOLVED=0 gets ON cleared, timer becomes 0, and the state returns to IDLE.
  - REVEAL=0: arming goes straight to IDLE with no hide.
  - Clearing autohide_en returns the state to IDLE and zeroes the timer.
  - If the expiry edge coincides with a bus write to a tile, the bus write to that tile wins.
  - SOLVED tiles are never hidden by the timer.
- Reset values: every tile, REVEAL, CTRL, the timer (state IDLE), the FIFO, overflow, btn_q and dataOut are 0. Consequently tile_on, tile_color, tile_solved and irq are 0.
- all_solved is 0 while in reset. Outside reset it is combinational, all ones only when every tile is solved.
- Asserting reset mid-operation clears everything immediately, regardless of timer state or FIFO contents.

Test Plan:
- Reset and map: write TILE[3]=0x0000_AB03. Then:
  - tile_on[3]=1, tile_solved[3]=1, tile_color[47:36]=12'h0AB.
  - Reading addr BASE+3 with rEn returns 0x0000_AB03 one cycle later.
  - Reading BASE+NUM_TILES+4 returns 0.
- FIFO: raise btn 4'b0001, then 4'b0101, then hold.
  - Two entries; irq=1.
  - Pops return 0x8000_0001, then 0x8000_0004, then 0x0000_0000; irq drops after the second pop.
- Overflow: generate 5 distinct rises with FIFO_DEPTH=4.
  - STATUS shows count=4 and bit1=1.
  - Writing STATUS=0x2 clears bit1; count stays 4.
  - A same-cycle push and pop leaves count at 4.
- Auto-hide: set CTRL=1 and REVEAL=3. Write TILE[0]=0x101 (ON) and TILE[1]=0x103 (ON, SOLVED), then apply 3 frame_ticks.
  - After the third tick, tile_on[0]=0 and tile_on[1]=1.
  - Re-arming after 2 ticks restarts the count from 3.
- All-solved and params: with NUM_TILES=4, set all SOLVED.
  - all_solved=1 and STATUS bit0=1.
  - Clearing one tile's SOLVED bit gives all_solved=0.
- Async reset: assert reset mid-COUNTING with the FIFO holding 2 entries, without a clock edge.
  - All outputs go to 0 immediately.
  - After release, reads return 0 and irq=0.

Source files
------------

// File: rtl/tile_board_mmio.sv
// tile_board_mmio: memory-mapped tile-state bank for the rotating memory game.
// It sits on the CPU data bus beside the RAM and drives packed tile vectors to the VGA controller.
// Besides the per-tile ON/SOLVED/COLOR registers it provides:
//   - a button-event FIFO;
//   - a frame-counted auto-hide timer for revealed tiles;
//   - an aggregate status register.
//
// Register map, word offsets from BASE_ADDR:
//   0..N-1  TILE[i]  bit0 ON, bit1 SOLVED, bits[8 +: COLOR_W] COLOR
//   N+0     REVEAL   reload value for the reveal timer, in frames
//   N+1     EVENT    read-to-pop: {valid, 27'b0, mask[3:0]}
//   N+2     STATUS   bit0 all_solved, bit1 overflow (write 1 to clear),
//                    bits[12:8] FIFO count, bits[31:16] timer
//   N+3     CTRL     bit0 autohide_en
//
// Ports:
//   clock, reset         system clock; asynchronous active-high reset
//   wEn, rEn, addr       bus strobes and word address
//   dataIn, dataOut      write data; registered read data (1-cycle latency)
//   btn                  synchronised button levels {BTND, BTNU, BTNL, BTNR}
//   frame_tick           one-cycle pulse per video frame
//   tile_on/_color/_solved  packed tile state for the video path
//   all_solved           AND of tile_solved (0 while in reset)
//   irq                  high while the event FIFO is non-empty
module tile_board_mmio #(
  parameter int unsigned       NUM_TILES  = 16,
  parameter int unsigned       COLOR_W    = 12,
  parameter int unsigned       ADDR_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 12'hF00,
  parameter int unsigned       TIMER_W    = 16,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wEn,
  input  logic                         rEn,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [31:0]                  dataIn,
  output logic [31:0]                  dataOut,
  input  logic [3:0]                   btn,
  input  logic                         frame_tick,
  output logic [NUM_TILES-1:0]         tile_on,
  output logic [NUM_TILES*COLOR_W-1:0] tile_color,
  output logic [NUM_TILES-1:0]         tile_solved,
  output logic                         all_solved,
  output logic                         irq
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [ADDR_W-1:0] OFF_REVEAL = ADDR_W'(NUM_TILES);
  localparam logic [ADDR_W-1:0] OFF_EVENT  = ADDR_W'(NUM_TILES + 1);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(NUM_TILES + 2);
  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(NUM_TILES + 3);
  localparam logic [ADDR_W-1:0] OFF_END    = ADDR_W'(NUM_TILES + 4);
  localparam logic [CNT_W-1:0]  FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic {StIdle = 1'b0, StCounting = 1'b1} state_e;

  // Tile state
  logic [NUM_TILES-1:0] r_on;
  logic [NUM_TILES-1:0] r_solved;
  logic [COLOR_W-1:0]   r_color [NUM_TILES];

  // Control / timer state
  logic [TIMER_W-1:0] r_reveal;
  logic               r_autohide;
  state_e             r_state;
  state_e             w_state_d;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_d;
  logic               w_expire;

  // Event FIFO
  logic [3:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [3:0]       r_btn_q;

  // Decode
  logic [ADDR_W-1:0] w_off;
  logic              w_hit;
  logic              w_wr;
  logic              w_tile_wr;
  logic              w_arm;
  logic              w_ctrl_clr;
  logic [31:0]       w_rdata;

  logic [3:0] w_rise;
  logic       w_push_req;
  logic       w_push;
  logic       w_pop;
  logic       w_empty;
  logic       w_full;
  logic       w_ovf_set;

  logic w_unused;
  assign w_unused = ^dataIn;

  assign w_off      = addr - BASE_ADDR;
  assign w_hit      = (addr >= BASE_ADDR) && (w_off < OFF_END);
  assign w_wr       = wEn && w_hit;
  assign w_tile_wr  = w_wr && (w_off < OFF_REVEAL);
  // Revealing an unsolved tile (re)starts the shared hide countdown.
  assign w_arm      = w_tile_wr && dataIn[0] && !dataIn[1] && r_autohide;
  assign w_ctrl_clr = w_wr && (w_off == OFF_CTRL) && !dataIn[0];

  // ---------------------------------------------------------------------------
  // Button edge detection and FIFO control
  // ---------------------------------------------------------------------------
  assign w_rise     = btn & ~r_btn_q;
  assign w_push_req = |w_rise;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FIFO_FULL);
  // A write in the same cycle wins over the read, so no pop then.
  assign w_pop      = rEn && !wEn && w_hit && (w_off == OFF_EVENT) && !w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btn_q <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      r_btn_q <= btn;
      if (w_push) begin
        r_fifo[r_wptr] <= w_rise;
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_wr && (w_off == OFF_STATUS) && dataIn[1]) r_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reveal timer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    w_timer_d = r_timer;
    w_expire  = 1'b0;
    case (r_state)
      StCounting: begin
        if (frame_tick) begin
          if (r_timer == TIMER_W'(1)) begin
            w_expire  = 1'b1;
            w_timer_d = '0;
            w_state_d = StIdle;
          end else begin
            w_timer_d = r_timer - TIMER_W'(1);
          end
        end
      end
      default: ;
    endcase
    // A restart overrides any countdown step in the same cycle.
    if (w_arm) begin
      if (r_reveal == '0) begin
        w_timer_d = '0;
        w_state_d = StIdle;
      end else begin
        w_timer_d = r_reveal;
        w_state_d = StCounting;
      end
    end
    if (w_ctrl_clr) begin
      w_timer_d = '0;
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_timer    <= '0;
      r_reveal   <= '0;
      r_autohide <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_timer <= w_timer_d;
      if (w_wr && (w_off == OFF_REVEAL)) r_reveal <= dataIn[TIMER_W-1:0];
      if (w_wr && (w_off == OFF_CTRL)) r_autohide <= dataIn[0];
    end
  end

  // ---------------------------------------------------------------------------
  // Tile registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_on     <= '0;
      r_solved <= '0;
      for (int i = 0; i < NUM_TILES; i++) r_color[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_TILES; i++) begin
        if (w_expire && r_on[i] && !r_solved[i]) r_on[i] <= 1'b0;
        // Placed after the hide so a coincident bus write to this tile wins.
        if (w_tile_wr && (w_off == ADDR_W'(i))) begin
          r_on[i]     <= dataIn[0];
          r_solved[i] <= dataIn[1];
          r_color[i]  <= dataIn[8 +: COLOR_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      for (int i = 0; i < NUM_TILES; i++) begin
        if (w_off == ADDR_W'(i)) w_rdata = 32'({r_color[i], 6'b0, r_solved[i], r_on[i]});
      end
      if (w_off == OFF_REVEAL) w_rdata = 32'(r_reveal);
      // Shows the head even when a coincident write suppresses the pop.
      if ((w_off == OFF_EVENT) && !w_empty) w_rdata = {1'b1, 27'b0, r_fifo[r_rptr]};
      if (w_off == OFF_STATUS) begin
        w_rdata[0]     = &r_solved;
        w_rdata[1]     = r_ovf;
        w_rdata[12:8]  = 5'(r_count);
        w_rdata[31:16] = 16'(r_timer);
      end
      if (w_off == OFF_CTRL) w_rdata[0] = r_autohide;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) dataOut <= '0;
    else if (rEn) dataOut <= w_rdata;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    tile_color = '0;
    for (int i = 0; i < NUM_TILES; i++) tile_color[i*COLOR_W +: COLOR_W] = r_color[i];
  end

  assign tile_on     = r_on;
  assign tile_solved = r_solved;
  assign all_solved  = !reset && (&r_solved);
  assign irq         = !w_empty;

endmodule

// File: tb/tb_tile_board_mmio.sv
module tb_tile_board_mmio;

  localparam int         NT   = 16;
  localparam int         DEP  = 4;
  localparam logic [11:0] BASE = 12'hF00;
  localparam logic [11:0] A_REV = BASE + 12'(NT);
  localparam logic [11:0] A_EVT = BASE + 12'(NT + 1);
  localparam logic [11:0] A_STS = BASE + 12'(NT + 2);
  localparam logic [11:0] A_CTL = BASE + 12'(NT + 3);

  logic         clock, reset, wEn, rEn, frame_tick;
  logic [11:0]  addr;
  logic [31:0]  dataIn, dataOut, dataOut4;
  logic [3:0]   btn;
  logic [NT-1:0] tile_on, tile_solved;
  logic [NT*12-1:0] tile_color;
  logic         all_solved, irq;
  logic [3:0]   tile_on4, tile_solved4;
  logic [47:0]  tile_color4;
  logic         all_solved4, irq4;

  int total = 0;
  int bad   = 0;

  tile_board_mmio u_dut (
    .clock(clock), .reset(reset), .wEn(wEn), .rEn(rEn), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .btn(btn), .frame_tick(frame_tick), .tile_on(tile_on),
    .tile_color(tile_color), .tile_solved(tile_solved), .all_solved(all_solved), .irq(irq)
  );

  tile_board_mmio #(.NUM_TILES(4), .BASE_ADDR(12'h100)) u_dut4 (
    .clock(clock), .reset(reset), .wEn(wEn), .rEn(rEn), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut4), .btn(btn), .frame_tick(frame_tick), .tile_on(tile_on4),
    .tile_color(tile_color4), .tile_solved(tile_solved4), .all_solved(all_solved4), .irq(irq4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: tile arrays, a queue for the event FIFO, and a frame countdown
  // where a nonzero remaining count means the timer is running.
  int         m_on [NT];
  int         m_sol [NT];
  int         m_col [NT];
  int         m_reveal, m_auto, m_timer, m_ovf;
  logic [3:0] m_q [$];
  logic [3:0] m_prev;
  logic [31:0] m_dout;

  function automatic void model_reset();
    for (int i = 0; i < NT; i++) begin
      m_on[i] = 0; m_sol[i] = 0; m_col[i] = 0;
    end
    m_reveal = 0; m_auto = 0; m_timer = 0; m_ovf = 0;
    m_q.delete();
    m_prev = 4'h0;
    m_dout = 32'h0;
  endfunction

  function automatic int model_all();
    int all = 1;
    for (int i = 0; i < NT; i++) if (m_sol[i] == 0) all = 0;
    return all;
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    int ai  = int'(a);
    int off = ai - int'(BASE);
    int v   = 0;
    if (ai >= int'(BASE) && off < NT + 4) begin
      if (off < NT) v = (m_col[off] << 8) | (m_sol[off] << 1) | m_on[off];
      else if (off == NT) v = m_reveal;
      else if (off == NT + 1) v = (m_q.size() > 0) ? (32'h8000_0000 | int'(m_q[0])) : 0;
      else if (off == NT + 2) v = model_all() | (m_ovf << 1) | (m_q.size() << 8) | (m_timer << 16);
      else v = m_auto;
    end
    return 32'(v);
  endfunction

  function automatic void model_step(input logic w, input logic r, input logic [11:0] a,
                                     input logic [31:0] d, input logic [3:0] b,
                                     input logic ft);
    logic [31:0] rv = model_read(a);
    int  off = int'(a) - int'(BASE);
    bit  hit = (int'(a) >= int'(BASE)) && (off < NT + 4);
    bit  expire = ft && (m_timer == 1);
    bit  arm = w && hit && off < NT && d[0] && !d[1] && (m_auto != 0);
    bit  pop = r && !w && hit && off == NT + 1 && m_q.size() > 0;
    logic [3:0] rise = b & ~m_prev;
    int  tnext;
    m_prev = b;
    if (w && hit && off == NT + 3 && !d[0]) tnext = 0;
    else if (arm) tnext = m_reveal;
    else if (ft && m_timer > 0) tnext = m_timer - 1;
    else tnext = m_timer;
    if (expire) for (int i = 0; i < NT; i++) if (m_sol[i] == 0) m_on[i] = 0;
    if (w && hit) begin
      if (off < NT) begin
        m_on[off] = int'(d[0]); m_sol[off] = int'(d[1]); m_col[off] = int'(d[19:8]);
      end else if (off == NT) m_reveal = int'(d[15:0]);
      else if (off == NT + 2 && d[1]) m_ovf = 0;
      else if (off == NT + 3) m_auto = int'(d[0]);
    end
    if (pop) void'(m_q.pop_front());
    if (rise != 4'h0) begin
      if (m_q.size() < DEP) m_q.push_back(rise);
      else m_ovf = 1;
    end
    if (r) m_dout = rv;
    m_timer = tnext;
  endfunction

  task automatic step(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d,
                      input logic ft);
    wEn = w; rEn = r; addr = a; dataIn = d; frame_tick = ft;
    model_step(w, r, a, d, btn, ft);
    @(posedge clock);
    #1;
    wEn = 1'b0; rEn = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b0, 1'b1, a, 32'h0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0);
  endtask

  task automatic tick();
    step(1'b0, 1'b0, 12'h000, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    total++;
    if ({tile_on, tile_solved, all_solved, irq} !== '0) begin
      bad++;
      $display("FAIL reset_flags got=%h/%h/%b/%b want=0", tile_on, tile_solved, all_solved, irq);
    end
    total++;
    if (tile_color !== '0 || dataOut !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got color=%h dout=%h want=0", tile_color, dataOut);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_map();
    wr(BASE + 12'd3, 32'h0000_AB03);
    total++;
    if (tile_on[3] !== 1'b1 || tile_solved[3] !== 1'b1 || tile_color[47:36] !== 12'h0AB) begin
      bad++;
      $display("FAIL map_tile3 got on=%b sol=%b col=%h want 1 1 0ab",
               tile_on[3], tile_solved[3], tile_color[47:36]);
    end
    rd(BASE + 12'd3);
    total++;
    if (dataOut !== 32'h0000_AB03) begin
      bad++;
      $display("FAIL map_read3 got=%h want=0000ab03", dataOut);
    end
    rd(BASE + 12'(NT + 4));
    total++;
    if (dataOut !== 32'h0) begin
      bad++;
      $display("FAIL map_unmapped got=%h want=0", dataOut);
    end
  endtask

  task automatic test_fifo();
    btn = 4'b0001; idle();
    btn = 4'b0101; idle();
    idle();
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL fifo_irq got=%b want=1", irq);
    end
    rd(A_STS);
    total++;
    if (dataOut[12:8] !== 5'd2) begin
      bad++;
      $display("FAIL fifo_count got=%0d want=2", dataOut[12:8]);
    end
    rd(A_EVT);
    total++;
    if (dataOut !== 32'h8000_0001) begin
      bad++;
      $display("FAIL fifo_pop1 got=%h want=80000001", dataOut);
    end
    rd(A_EVT);
    total++;
    if (dataOut !== 32'h8000_0004) begin
      bad++;
      $display("FAIL fifo_pop2 got=%h want=80000004", dataOut);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL fifo_irq_drop got=%b want=0", irq);
    end
    rd(A_EVT);
    total++;
    if (dataOut !== 32'h0) begin
      bad++;
      $display("FAIL fifo_pop_empty got=%h want=0", dataOut);
    end
    btn = 4'b0000; idle();
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) begin
      btn = 4'b0001; idle();
      btn = 4'b0000; idle();
    end
    rd(A_STS);
    total++;
    if (dataOut !== 32'h0000_0402) begin
      bad++;
      $display("FAIL ovf_status got=%h want=00000402", dataOut);
    end
    wr(A_STS, 32'h2);
    rd(A_STS);
    total++;
    if (dataOut !== 32'h0000_0400) begin
      bad++;
      $display("FAIL ovf_clear got=%h want=00000400", dataOut);
    end
    btn = 4'b0001;
    rd(A_EVT);
    total++;
    if (dataOut !== 32'h8000_0001) begin
      bad++;
      $display("FAIL ovf_pushpop got=%h want=80000001", dataOut);
    end
    btn = 4'b0000;
    rd(A_STS);
    total++;
    if (dataOut !== 32'h0000_0400) begin
      bad++;
      $display("FAIL ovf_pushpop_cnt got=%h want=00000400", dataOut);
    end
    for (int k = 0; k < DEP; k++) rd(A_EVT);
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL ovf_drain got=%b want=0", irq);
    end
  endtask

  task automatic test_autohide();
    wr(A_CTL, 32'h1);
    wr(A_REV, 32'd3);
    wr(BASE + 12'd0, 32'h101);
    wr(BASE + 12'd1, 32'h103);
    tick(); idle(); tick(); idle();
    total++;
    if (tile_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL hide_early got=%b want=1", tile_on[0]);
    end
    tick();
    total++;
    if (tile_on[0] !== 1'b0 || tile_on[1] !== 1'b1 || tile_on[3] !== 1'b1) begin
      bad++;
      $display("FAIL hide_expire got on0=%b on1=%b on3=%b want 0 1 1",
               tile_on[0], tile_on[1], tile_on[3]);
    end
    wr(BASE + 12'd0, 32'h101);
    tick(); tick();
    wr(BASE + 12'd0, 32'h101);
    rd(A_STS);
    total++;
    if (dataOut[31:16] !== 16'd3) begin
      bad++;
      $display("FAIL hide_rearm got=%0d want=3", dataOut[31:16]);
    end
    tick(); tick();
    total++;
    if (tile_on[0] !== 1'b1) begin
      bad++;
      $display("FAIL hide_rearm_hold got=%b want=1", tile_on[0]);
    end
    tick();
    total++;
    if (tile_on[0] !== 1'b0) begin
      bad++;
      $display("FAIL hide_rearm_expire got=%b want=0", tile_on[0]);
    end
    wr(A_CTL, 32'h0);
  endtask

  task automatic test_all_solved();
    for (int i = 0; i < 4; i++) wr(12'h100 + 12'(i), 32'h2);
    total++;
    if (all_solved4 !== 1'b1) begin
      bad++;
      $display("FAIL allsol_set got=%b want=1", all_solved4);
    end
    rd(12'h106);
    total++;
    if (dataOut4[0] !== 1'b1) begin
      bad++;
      $display("FAIL allsol_status got=%b want=1", dataOut4[0]);
    end
    wr(12'h102, 32'h0);
    total++;
    if (all_solved4 !== 1'b0) begin
      bad++;
      $display("FAIL allsol_clear got=%b want=0", all_solved4);
    end
  endtask

  task automatic test_random();
    logic [NT-1:0]    e_on, e_sol;
    logic [NT*12-1:0] e_col;
    logic [11:0]      a;
    logic [31:0]      d;
    for (int c = 0; c < 400; c++) begin
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : BASE + 12'($urandom_range(0, 21));
      d = $urandom;
      if (a == A_REV) d = $urandom_range(0, 6);
      if (a == A_CTL) d = 32'($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 3) == 0) btn = 4'($urandom);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, a, d, $urandom_range(0, 2) == 0);
      for (int i = 0; i < NT; i++) begin
        e_on[i] = m_on[i][0];
        e_sol[i] = m_sol[i][0];
        e_col[i*12 +: 12] = 12'(m_col[i]);
      end
      total++;
      if (dataOut !== m_dout) begin
        bad++;
        $display("FAIL rnd_dout cyc=%0d got=%h want=%h", c, dataOut, m_dout);
      end
      total++;
      if (tile_on !== e_on) begin
        bad++;
        $display("FAIL rnd_on cyc=%0d got=%h want=%h", c, tile_on, e_on);
      end
      total++;
      if (tile_solved !== e_sol) begin
        bad++;
        $display("FAIL rnd_solved cyc=%0d got=%h want=%h", c, tile_solved, e_sol);
      end
      total++;
      if (tile_color !== e_col) begin
        bad++;
        $display("FAIL rnd_color cyc=%0d got=%h want=%h", c, tile_color, e_col);
      end
      total++;
      if (all_solved !== 1'(model_all())) begin
        bad++;
        $display("FAIL rnd_allsol cyc=%0d got=%b want=%0d", c, all_solved, model_all());
      end
      total++;
      if (irq !== (m_q.size() != 0)) begin
        bad++;
        $display("FAIL rnd_irq cyc=%0d got=%b want=%0d", c, irq, m_q.size() != 0);
      end
    end
    btn = 4'b0000; idle();
  endtask

  task automatic test_async_reset();
    wr(A_CTL, 32'h1);
    wr(A_REV, 32'd10);
    wr(BASE + 12'd5, 32'h0000_0501);
    btn = 4'b0001; idle();
    btn = 4'b0000; idle();
    btn = 4'b0010; idle();
    btn = 4'b0000;
    rd(BASE + 12'd5);
    total++;
    if (irq !== 1'b1 || tile_on[5] !== 1'b1 || dataOut !== 32'h501) begin
      bad++;
      $display("FAIL arst_setup got irq=%b on5=%b dout=%h want 1 1 501", irq, tile_on[5], dataOut);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({tile_on, tile_solved, all_solved, irq} !== '0) begin
      bad++;
      $display("FAIL arst_flags got=%h/%h/%b/%b want=0", tile_on, tile_solved, all_solved, irq);
    end
    total++;
    if (tile_color !== '0 || dataOut !== 32'h0) begin
      bad++;
      $display("FAIL arst_data got color=%h dout=%h want=0", tile_color, dataOut);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    rd(A_STS);
    total++;
    if (dataOut !== 32'h0) begin
      bad++;
      $display("FAIL arst_status got=%h want=0", dataOut);
    end
    rd(BASE + 12'd5);
    total++;
    if (dataOut !== 32'h0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL arst_after got dout=%h irq=%b want 0 0", dataOut, irq);
    end
  endtask

  initial begin
    reset = 1'b1; wEn = 1'b0; rEn = 1'b0; addr = '0; dataIn = '0; btn = '0; frame_tick = 1'b0;
    model_reset();
    test_reset();
    test_map();
    test_fifo();
    test_overflow();
    test_autohide();
    test_all_solved();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
